// File: rtl/div_seq.sv
// div_seq: iterative unsigned restoring divider.
// Produces one quotient bit per clock, so a result takes WIDTH cycles after
// the operand pair is accepted. Operands come in on a valid/ready handshake
// and results go out on a second one. Every output is driven from a register.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;        // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] r_div;      // divisor captured on accept
    logic [WIDTH-1:0] r_rem;      // partial remainder; after each step it is < divisor, so WIDTH bits suffice
    logic [CW-1:0]    r_cnt;      // steps left
    logic             r_zero;     // captured divisor was zero
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_dbz;

    // One restoring step: the shifted remainder needs WIDTH+1 bits for the compare.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    // The difference is always below the divisor, so the low WIDTH bits are exact.
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    // Handshake FSM plus datapath; all outputs registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= dividend;
                        r_div      <= divisor;
                        r_rem      <= '0;
                        r_cnt      <= CW'(WIDTH);
                        r_zero     <= (divisor == '0);
                        r_dbz      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_dbz       <= r_zero;
                        // With a zero divisor every step subtracts nothing, so the
                        // remainder register already ends up holding the dividend;
                        // the quotient is forced explicitly to all ones.
                        if (r_zero) begin
                            r_q <= '1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks on an 8-bit divider and a randomized
// back-to-back sweep on a 16-bit divider, checked against plain / and %.
module tb_div_seq;

    logic clk;
    logic reset_n;

    // 8-bit instance
    logic       iv8, ir8, ov8, or8, dz8;
    logic [7:0] a8, b8, q8, r8;
    // 16-bit instance
    logic        iv16, ir16, ov16, or16, dz16;
    logic [15:0] a16, b16, q16, r16;

    int vectors     = 0;
    int miscompares = 0;

    div_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv8), .in_ready(ir8), .dividend(a8), .divisor(b8),
        .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    div_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(iv16), .in_ready(ir16), .dividend(a16), .divisor(b16),
        .out_valid(ov16), .out_ready(or16),
        .quotient(q16), .remainder(r16), .div_by_zero(dz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair to the 8-bit divider and return once it has been accepted.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (!ir8 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, ir8, 1'b1);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
    endtask

    // Full transaction: accept, check latency and result, then hand it off.
    task automatic div8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez,
                        input string tag);
        int n;
        accept8(a, b, tag);
        n = 0;
        while (!ov8 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_q"}, q8, eq);
        check({tag, "_r"}, r8, er);
        check({tag, "_dbz"}, dz8, ez);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, "_released"}, {ov8, ir8}, 2'b01);
        $display("div8 %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d", a, b, q8, r8, dz8, n);
    endtask

    // Randomized sweep state for the 16-bit instance
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;
    pair_t pending[$];

    function automatic logic [15:0] rand_divisor();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 16'd0;
        if (sel < 4)  return 16'($urandom_range(1, 15));
        return 16'($urandom);
    endfunction

    initial begin
        int n;
        int accepts;
        int results;
        int cycles;
        pair_t exp_pair;
        logic [15:0] eq, er;
        logic ez;

        reset_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
        #23;
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst8_in_ready", ir8, 1'b1);
        check("rst8_out_valid", ov8, 1'b0);
        check("rst8_q", q8, 8'd0);
        check("rst8_r", r8, 8'd0);
        check("rst8_dbz", dz8, 1'b0);
        check("rst16_ready_valid", {ir16, ov16}, 2'b10);

        // Directed cases
        div8(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "basic");
        div8(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, "small");
        div8(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "full");
        div8(8'd5, 8'd0, 8'd255, 8'd5, 1'b1, "zero");
        div8(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, "zero_zero");
        div8(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, "max_div");

        // Backpressure and input isolation: 200/9 with noise during BUSY
        accept8(8'd200, 8'd9, "bp");
        for (int i = 0; i < 4; i++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            iv8 = i[0];
            check("bp_busy_in_ready", ir8, 1'b0);
            tick();
        end
        iv8 = 1'b0;
        n = 4;
        while (!ov8 && n < 40) begin
            tick();
            n++;
        end
        check("bp_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", ov8, 1'b1);
            check("bp_hold_q", q8, 8'd22);
            check("bp_hold_r", r8, 8'd2);
            check("bp_hold_in_ready", ir8, 1'b0);
            tick();
        end
        $display("bp 200/9 held 5 cycles -> q=%0d r=%0d", q8, r8);
        or8 = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov8) n++;
            tick();
        end
        or8 = 1'b0;
        check("bp_single_result", n, 0);

        // Asynchronous reset mid-operation
        accept8(8'd77, 8'd3, "rst_mid");
        tick(); tick(); tick();       // now in the 4th BUSY cycle
        #2;
        reset_n = 1'b0;
        #1;                           // still well before the next edge
        check("rst_mid_async", {ir8, ov8, q8, r8, dz8}, {1'b1, 1'b0, 8'd0, 8'd0, 1'b0});
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov8) n++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov8) n++;
        end
        check("rst_mid_no_result", n, 0);
        $display("reset mid-BUSY: outputs cleared, no result");
        div8(8'd77, 8'd3, 8'd25, 8'd2, 1'b0, "rst_after");

        // Randomized back-to-back sweep on the 16-bit divider
        accepts = 0;
        results = 0;
        cycles  = 0;
        a16  = 16'($urandom);
        b16  = rand_divisor();
        iv16 = 1'b1;
        or16 = 1'b1;
        while (results < 1000 && cycles < 60000) begin
            // Handshakes at the coming edge are decided by what is visible now.
            if (ov16 && or16) begin
                if (pending.size() == 0) begin
                    check("sweep_unexpected_result", 1'b1, 1'b0);
                end else begin
                    exp_pair = pending.pop_front();
                    if (exp_pair.b == 0) begin
                        eq = 16'hFFFF;
                        er = exp_pair.a;
                        ez = 1'b1;
                    end else begin
                        eq = exp_pair.a / exp_pair.b;
                        er = exp_pair.a % exp_pair.b;
                        ez = 1'b0;
                    end
                    check("sweep_q", q16, eq);
                    check("sweep_r", r16, er);
                    check("sweep_dbz", dz16, ez);
                    $display("div16 #%0d %0d/%0d -> q=%0d r=%0d dbz=%0d", results, exp_pair.a, exp_pair.b, q16, r16, dz16);
                end
                results++;
            end
            if (iv16 && ir16) begin
                pending.push_back('{a: a16, b: b16});
                accepts++;
            end
            tick();
            cycles++;
            // Upstream holds its pair until accepted, then offers a fresh one.
            if (ir16 == 1'b0 && accepts > 0 && iv16 && pending.size() > 0 && accepts < 1000) begin
                a16 = 16'($urandom);
                b16 = rand_divisor();
            end
            if (accepts >= 1000) iv16 = 1'b0;
            or16 = ($urandom_range(0, 3) != 0);
        end
        check("sweep_result_count", results, 1000);
        check("sweep_accept_count", accepts, results);
        check("sweep_queue_empty", pending.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative unsigned integer divider: the sequential inverse of the combinational multiplier primitive. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per cycle using restoring division. It returns quotient and remainder over a second valid/ready handshake. It sits in the primitive library beside the arithmetic operators, for designs where a combinational divider is too large or too slow.

## Interface
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous reset, active-low
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operand pair
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  quotient/remainder present
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result came from divisor == 0

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1, out_valid=0.
  - If in_valid is high at a rising edge, the block captures dividend into the quotient shift register and divisor into the divisor register.
  - It clears the (WIDTH+1)-bit partial remainder, loads the iteration counter with WIDTH, latches divisor==0, and moves to BUSY.
- BUSY
  - in_ready=0, out_valid=0.
  - Each edge performs one restoring step:
    - r' = {r[WIDTH-1:0], q[WIDTH-1]}
    - q shifts left by 1.
    - If r' >= {0,divisor}: r = r' - divisor and q[0]=1. Otherwise r = r' and q[0]=0.
  - The counter decrements on every step. After the step taken when the counter equals 1, the state moves to DONE.
- DONE
  - out_valid=1, in_ready=0.
  - quotient=q and remainder=r[WIDTH-1:0]; both hold stable until the handshake.
  - out_valid && out_ready at an edge returns the block to IDLE.
  - A new operand is accepted no earlier than the following edge; there is no same-cycle turnaround.
- Divide by zero
  - The iteration still runs WIDTH steps, so latency is constant.
  - On entry to DONE, quotient is forced to all ones, remainder is forced to the captured dividend, and div_by_zero=1.
  - In all other cases div_by_zero=0.
- Invariant on every non-zero-divisor result: dividend == quotient*divisor + remainder, and remainder < divisor.
- Inputs are sampled only on the accept edge. Later changes on dividend/divisor have no effect on the result.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers are 0; state is IDLE.
- Reset is asynchronous: asserting reset_n low in any state (including mid-BUSY or DONE) immediately returns the block to reset values. The in-flight operation is discarded and no result is produced.
- Latency:
  - Accept edge t0. out_valid is high in the cycle after edge t0+WIDTH, i.e. WIDTH cycles after acceptance.
  - Independent of operand values.
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and the outputs stay unchanged for any number of cycles while out_ready=0.
- Protocol rules:
  - in_valid while in_ready=0 is ignored; the upstream holds it.
  - out_ready while out_valid=0 is ignored.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic divide, WIDTH=8: accept 100/7
  - quotient=14, remainder=2, div_by_zero=0.
  - out_valid first high exactly 8 cycles after the accept edge.
- Dividend smaller than divisor: 3/10 -> quotient=0, remainder=3. Full-range dividend: 255/1 -> quotient=255, remainder=0.
- Divide by zero: 5/0 -> quotient=255, remainder=5, div_by_zero=1, with the same 8-cycle latency.
- Backpressure and input isolation:
  - Accept 200/9, then change dividend/divisor and pulse in_valid during BUSY.
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Required: result stays 22/2 and stable the whole time; in_ready stays 0; exactly one result is delivered on release.
- Reset mid-operation:
  - Accept 77/3 and drop reset_n low on cycle 4 of BUSY.
  - Outputs go to reset values immediately, without waiting for a clock edge; no out_valid appears.
  - After release, 77/3 is accepted and returns 25/2.
- Randomized back-to-back sweep, WIDTH=16, 1000 pairs with random out_ready stalls: every result satisfies the invariant (or the divide-by-zero rule), and the result count equals the accept count.
